// File: rtl/axi_lite_master.sv
// AXI4-Lite master: turns a single-outstanding command/response handshake into
// AXI4-Lite read and write transactions. One transaction is in flight at a time.
// The data width is expected to be 32 or 64.
module axi_lite_master #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter logic [2:0]  C_M_AXI_PROT       = 3'b000
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESETN,
  // Command interface
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  // Response interface
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic                              rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              rsp_err,
  // Write address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  // Write data channel
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  // Write response channel
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  // Read address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  // Read data channel
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StWrResp,
    StRdAddr,
    StRdData,
    StRsp
  } state_e;

  state_e                          state_q, state_d;
  logic                            cmd_ready_q, cmd_ready_d;
  logic                            awvalid_q, awvalid_d;
  logic                            wvalid_q, wvalid_d;
  logic                            bready_q, bready_d;
  logic                            arvalid_q, arvalid_d;
  logic                            rready_q, rready_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic                            rsp_valid_q, rsp_valid_d;
  logic                            rsp_write_q, rsp_write_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                      rsp_resp_q, rsp_resp_d;

  // Next-state and registered-output computation for the shared read/write FSM.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    case (state_q)
      StIdle: begin
        // cmd_ready comes up one cycle after entering idle (reset or response done)
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          if (cmd_write) begin
            state_d   = StWr;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = StRdAddr;
            arvalid_d = 1'b1;
          end
        end
      end

      StWr: begin
        // A low VALID in this state marks that channel's handshake as done
        if (M_AXI_AWREADY) awvalid_d = 1'b0;
        if (M_AXI_WREADY)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = StWrResp;
          bready_d = 1'b1;
        end
      end

      StWrResp: begin
        if (M_AXI_BVALID && bready_q) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = M_AXI_BRESP;
          state_d     = StRsp;
        end
      end

      StRdAddr: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRdData;
        end
      end

      StRdData: begin
        if (M_AXI_RVALID && rready_q) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = M_AXI_RDATA;
          rsp_resp_d  = M_AXI_RRESP;
          state_d     = StRsp;
        end
      end

      StRsp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = rsp_write_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_err       = rsp_resp_q[1];

  // Reads and writes never overlap, so one address register serves both channels
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_AWPROT  = C_M_AXI_PROT;
  assign M_AXI_ARPROT  = C_M_AXI_PROT;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Self-checking bench for axi_lite_master: directed cases plus randomized
// reads/writes against a word-array reference memory and an AXI slave model.
module tb_axi_lite_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int          n_checks = 0;
  int          n_fail = 0;
  int          exp_wait;
  logic [31:0] ref_mem [16];
  logic [31:0] slave_mem [16];

  always #5 clk = ~clk;

  axi_lite_master dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESETN (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .cmd_wstrb     (cmd_wstrb),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_write     (rsp_write),
    .rsp_rdata     (rsp_rdata),
    .rsp_resp      (rsp_resp),
    .rsp_err       (rsp_err),
    .M_AXI_AWADDR  (awaddr),
    .M_AXI_AWPROT  (awprot),
    .M_AXI_AWVALID (awvalid),
    .M_AXI_AWREADY (awready),
    .M_AXI_WDATA   (wdata),
    .M_AXI_WSTRB   (wstrb),
    .M_AXI_WVALID  (wvalid),
    .M_AXI_WREADY  (wready),
    .M_AXI_BRESP   (bresp),
    .M_AXI_BVALID  (bvalid),
    .M_AXI_BREADY  (bready),
    .M_AXI_ARADDR  (araddr),
    .M_AXI_ARPROT  (arprot),
    .M_AXI_ARVALID (arvalid),
    .M_AXI_ARREADY (arready),
    .M_AXI_RDATA   (rdata),
    .M_AXI_RRESP   (rresp),
    .M_AXI_RVALID  (rvalid),
    .M_AXI_RREADY  (rready)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  // Present a command and wait (bounded) for acceptance; returns at the first VALID cycle.
  task automatic accept_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic keep);
    int waited;
    waited    = 0;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_wstrb = strb;
    cmd_valid = 1'b1;
    while (!cmd_ready && waited < 20) begin
      check_eq("idle_no_valid", {awvalid, wvalid, arvalid}, 3'b000);
      tick();
      waited++;
    end
    check_eq("cmd_accept_wait", waited, exp_wait);
    tick();
    if (!keep) cmd_valid = 1'b0;
  endtask

  // Response phase: hold rsp_ready low rsp_dly cycles, then complete the handshake.
  task automatic finish_rsp(input logic wr, input logic [31:0] exp_data, input logic [1:0] resp,
                            input int rsp_dly);
    for (int i = 0; i <= rsp_dly; i++) begin
      rsp_ready = (i == rsp_dly);
      check_eq("rsp_fields", {rsp_valid, rsp_write, rsp_err, rsp_resp, rsp_rdata},
               {1'b1, wr, resp[1], resp, exp_data});
      check_eq("rsp_quiet", {awvalid, wvalid, arvalid, bready, rready, cmd_ready}, 6'b0);
      tick();
    end
    rsp_ready = 1'b0;
    check_eq("rsp_done", {rsp_valid, cmd_ready}, 2'b01);
    exp_wait = 0;
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int b_dly, input logic [1:0] resp, input int rsp_dly,
                           input logic keep);
    int          mx, hb;
    logic [3:0]  s_idx, s_strb;
    logic [31:0] s_data;
    mx = (aw_dly > w_dly) ? aw_dly : w_dly;
    hb = mx + b_dly;
    s_idx = '0; s_strb = '0; s_data = '0;
    accept_cmd(1'b1, addr, data, strb, keep);
    ref_mem[addr[5:2]] = merge(ref_mem[addr[5:2]], data, strb);
    for (int c = 0; c <= hb; c++) begin
      awready = (c == aw_dly);
      wready  = (c == w_dly);
      bvalid  = (c == hb);
      bresp   = (c == hb) ? resp : 2'b00;
      check_eq("wr_handshakes", {awvalid, wvalid, bready}, {c <= aw_dly, c <= w_dly, c > mx});
      check_eq("wr_others", {arvalid, rready, cmd_ready, rsp_valid}, 4'b0);
      if (c <= aw_dly) check_eq("awaddr", {awprot, awaddr}, {3'b000, addr});
      if (c <= w_dly) check_eq("wdata", {wstrb, wdata}, {strb, data});
      if (c == aw_dly) s_idx = awaddr[5:2];
      if (c == w_dly) begin
        s_data = wdata;
        s_strb = wstrb;
      end
      tick();
    end
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    slave_mem[s_idx] = merge(slave_mem[s_idx], s_data, s_strb);
    finish_rsp(1'b1, 32'h0, resp, rsp_dly);
  endtask

  task automatic run_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                          input logic [1:0] resp, input int rsp_dly, input logic keep);
    int          hr;
    logic [3:0]  s_idx;
    logic [31:0] exp_data;
    hr = ar_dly + r_dly;
    s_idx = '0;
    exp_data = ref_mem[addr[5:2]];
    accept_cmd(1'b0, addr, $urandom, 4'($urandom), keep);
    for (int c = 0; c <= hr; c++) begin
      arready = (c == ar_dly);
      rvalid  = (c == hr);
      rdata   = (c == hr) ? slave_mem[s_idx] : $urandom;
      rresp   = (c == hr) ? resp : 2'b00;
      check_eq("rd_handshakes", {arvalid, rready}, {c <= ar_dly, c > ar_dly});
      check_eq("rd_others", {awvalid, wvalid, bready, cmd_ready, rsp_valid}, 5'b0);
      if (c <= ar_dly) check_eq("araddr", {arprot, araddr}, {3'b000, addr});
      if (c == ar_dly) s_idx = araddr[5:2];
      tick();
    end
    arready = 1'b0; rvalid = 1'b0; rresp = 2'b00;
    finish_rsp(1'b0, exp_data, resp, rsp_dly);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i]   = $urandom;
      slave_mem[i] = ref_mem[i];
    end
    ref_mem[2]   = 32'h1234_5678;
    slave_mem[2] = 32'h1234_5678;

    // Reset values, both before and after clock edges under reset
    #1;
    check_eq("reset_ctrl", {cmd_ready, awvalid, wvalid, arvalid, bready, rready, rsp_valid,
                            rsp_write, rsp_err, rsp_resp}, 11'b0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_data", {awaddr, araddr, wdata, wstrb, rsp_rdata}, 132'b0);
    check_eq("reset_cmd_ready", cmd_ready, 1'b0);
    #2 rst_n = 1'b1;
    exp_wait = 1;

    // 1: single-cycle AW/W, OKAY
    run_write(32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 0, 0, 1, 2'b00, 0, 1'b0);
    // 2: AW in cycle 1, W in cycle 4
    run_write(32'h0000_0010, 32'hA5A5_1234, 4'h3, 0, 3, 2, 2'b00, 0, 1'b0);
    // 3: read with slow ARREADY/RVALID and SLVERR
    run_read(32'h0000_0008, 2, 4, 2'b10, 0, 1'b0);
    check_eq("t3_rdata_const", ref_mem[2], 32'h1234_5678);
    // 4/5: stalled response with cmd_valid held, then back-to-back read
    run_write(32'h0000_0008, 32'h0BAD_F00D, 4'hC, 1, 0, 1, 2'b11, 5, 1'b1);
    run_read(32'h0000_0008, 0, 1, 2'b00, 0, 1'b1);
    run_read(32'h0000_0004, 1, 2, 2'b00, 0, 1'b0);

    // 6: reset mid-transaction with AW done and W pending
    accept_cmd(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'hF, 1'b0);
    awready = 1'b1;
    check_eq("t6_valids_c0", {awvalid, wvalid}, 2'b11);
    tick();
    awready = 1'b0;
    check_eq("t6_valids_c1", {awvalid, wvalid}, 2'b01);
    #3 rst_n = 1'b0;
    #1;
    check_eq("t6_async_clear", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready},
             7'b0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    exp_wait = 1;
    run_write(32'h0000_0020, 32'h1357_9BDF, 4'hF, 1, 2, 1, 2'b00, 1, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 1) == 1)
        run_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(1, 3), 2'($urandom), $urandom_range(0, 3),
                  1'($urandom));
      else
        run_read(a, $urandom_range(0, 3), $urandom_range(1, 4), 2'($urandom),
                 $urandom_range(0, 3), 1'($urandom));
    end
    cmd_valid = 1'b0;

    for (int i = 0; i < 16; i++) check_eq("final_mem", slave_mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- AXI4-Lite master (initiator) that converts a single-outstanding command/response interface into AXI4-Lite read and write transactions.
- It is the counterpart of our AXI4-Lite slave interface. It drives register accesses from internal controllers and from testbenches into any AXI4-Lite slave in the design.
- One transaction is in flight at a time. Read and write share a single FSM.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, address width of AXI and cmd_addr.
- C_M_AXI_DATA_WIDTH, 32, data width. Must be 32 or 64. Strobe width = DATA_WIDTH/8.
- C_M_AXI_PROT, 3'b000, constant driven on AWPROT/ARPROT.

Ports:
- M_AXI_ACLK  in  1  clock
- M_AXI_ARESETN  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  DATA_WIDTH/8  write strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_write  out  1  response belongs to a write
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- rsp_resp  out  2  captured BRESP/RRESP
- rsp_err  out  1  rsp_resp[1]
- M_AXI_AWADDR/AWPROT/AWVALID out, M_AXI_AWREADY in  (ADDR_WIDTH/3/1/1)  write address channel
- M_AXI_WDATA/WSTRB/WVALID out, M_AXI_WREADY in  (DATA_WIDTH/DATA_WIDTH/8/1/1)  write data channel
- M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1  write response channel
- M_AXI_ARADDR/ARPROT/ARVALID out, M_AXI_ARREADY in  (ADDR_WIDTH/3/1/1)  read address channel
- M_AXI_RDATA in DATA_WIDTH, M_AXI_RRESP in 2, M_AXI_RVALID in 1, M_AXI_RREADY out 1  read data channel

Behaviour:
- **Clock and reset:** single clock M_AXI_ACLK. Reset M_AXI_ARESETN is asynchronous, active-low. All flops clear immediately on the falling edge of reset.
- **Reset values:**
  - All VALID/READY outputs, rsp_*, AWADDR, ARADDR, WDATA and WSTRB are 0.
  - cmd_ready is 0 during reset and is registered. It rises on the first clock edge after reset deassertion.
  - State = IDLE.
- **FSM states:** IDLE, WR (AW/W phase), WR_RESP, RD_ADDR, RD_DATA, RSP.
- **IDLE:** cmd_ready=1. On cmd_valid & cmd_ready:
  - Capture addr, wdata and wstrb into the AXI output registers.
  - cmd_ready drops the next cycle.
  - Write: next state WR; AWVALID and WVALID rise together the next cycle.
  - Read: next state RD_ADDR; ARVALID rises the next cycle.
  - Latency from command accept to first VALID is 1 cycle.
- **WR:** internal flags aw_done and w_done.
  - AWVALID deasserts the cycle after AWVALID & AWREADY and is never reasserted in that transaction. WVALID behaves the same with WREADY.
  - Both handshakes in the same cycle, or the second one completing: go to WR_RESP next cycle.
  - AW and W may complete in either order, with any gap between them.
- **WR_RESP:** BREADY=1. On BVALID & BREADY:
  - Capture BRESP into rsp_resp; rsp_write=1, rsp_rdata=0.
  - BREADY drops, rsp_valid rises next cycle, go to RSP.
- **RD_ADDR:** ARVALID held until ARREADY. After the handshake, ARVALID=0 and RREADY=1 from the next cycle; go to RD_DATA.
- **RD_DATA:** RREADY=1. On RVALID & RREADY:
  - Capture RDATA into rsp_rdata and RRESP into rsp_resp; rsp_write=0.
  - RREADY drops, go to RSP.
- **RSP:**
  - rsp_valid=1; rsp_* held stable until rsp_ready.
  - On the rsp handshake: rsp_valid=0 and cmd_ready=1 on the next cycle, state IDLE.
  - Minimum command-to-command spacing is therefore 1 cycle after the rsp handshake.
- **AXI rules:**
  - Address, data, strobe and PROT are stable while the corresponding VALID is high and READY is low.
  - VALID never depends combinationally on READY.
  - BVALID/RVALID arriving early while the slave waits on BREADY/RREADY is legal and must simply be held by the slave.
- **Ignored inputs:** cmd_valid is ignored while cmd_ready=0. BVALID or RVALID outside WR_RESP/RD_DATA is ignored.
- **Response codes:** SLVERR (10) and DECERR (11) are passed through unchanged with rsp_err=1. The FSM flow is identical to OKAY.
- **Reset mid-transaction:** the outstanding transaction is abandoned and all VALID outputs drop immediately. The block returns to IDLE. The slave shares this reset.

Test Plan:
1. Write addr 0x0000_0004, data 0xDEADBEEF, strb 0xF; slave AWREADY=WREADY=1 in the first VALID cycle, BVALID one cycle later with OKAY.
   - Required: AWVALID/WVALID high exactly 1 cycle, BREADY high.
   - Required: rsp_valid with rsp_write=1, rsp_resp=00, rsp_err=0.
2. Write with AWREADY in cycle 1 and WREADY in cycle 4.
   - Required: AWVALID drops after cycle 1; WVALID and WDATA stay stable through cycle 4.
   - Required: exactly one B handshake and one response.
3. Read addr 0x0000_0008; ARREADY after 2 cycles; RVALID 4 cycles later with data 0x12345678 and RRESP=10.
   - Required: rsp_rdata=0x12345678, rsp_resp=10, rsp_err=1, rsp_write=0.
4. rsp_ready held low for 5 cycles after rsp_valid while cmd_valid stays high.
   - Required: rsp_* stable, cmd_ready=0, no AXI VALID asserted.
   - Required: on rsp_ready, the next command is accepted 1 cycle later.
5. Back-to-back write then read with cmd_valid held continuously.
   - Required: the read command is accepted only after the write's rsp handshake.
   - Required: ARADDR equals the new address and no write channel VALID reappears.
6. Assert M_AXI_ARESETN low mid-cycle while WVALID=1 and AWVALID already done.
   - Required: all VALID and rsp_valid go to 0 without waiting for a clock edge.
   - Required: cmd_ready=1 one cycle after release, and a new write completes normally.
